decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered instruction-decode pipeline stage between fetch and execute.
//  - Decodes the 32-bit MIPS-style word into the control bundle and operand fields.
//  - Adds R-type funct decode, beq/j, valid/ready handshakes on both sides,
//    a load-use interlock and a synchronous flush.
//  - Latency 1 cycle; control bundle held in one output register.
// PARAMETERS
//  DATA_W     32  instruction, PC and immediate width (>=32)
//  REG_AW     5   register-address width
//  ALU_OP_W   3   alu_op width; encodings are the `ALU_OP_* macros
//  STALL_CW   16  width of the saturating stall counter
// PORTS
//  clk            in   1         clock; all state on rising edge
//  rst_n          in   1         asynchronous, active-low reset
//  flush          in   1         synchronous pipeline flush (branch/jump taken)
//  in_valid       in   1         fetch presents an instruction
//  in_ready       out  1         stage accepts the instruction this cycle
//  in_ins         in   DATA_W    instruction word
//  in_pc          in   DATA_W    PC of in_ins
//  out_valid      out  1         output bundle valid
//  out_ready      in   1         execute consumes the bundle
//  out_pc         out  DATA_W    registered PC
//  out_rs/out_rt  out  REG_AW    source register fields
//  out_wr_reg     out  REG_AW    resolved destination (rd if reg_dst, else rt)
//  out_imm        out  DATA_W    sign-extended ins[15:0]
//  out_jtarget    out  26        ins[25:0]
//  out_reg_dst, out_alu_src, out_mem_to_reg, out_reg_write, out_mem_read,
//  out_mem_write, out_branch, out_jmp   out 1 each  control bits
//  out_alu_op     out  ALU_OP_W  ALU operation
//  stall_cnt      out  STALL_CW  load-use bubbles inserted, saturating
// BEHAVIOUR
//  Decode table (op / funct); all control bits 0 unless listed:
//  - op 0, funct 32/34/36/37/42 (add/sub/and/or/slt): reg_dst, reg_write; alu_op ADD/SUB/AND/OR/SLT.
//  - Any other funct under op 0: NOP, all controls 0.
//  - op 8 addi:  alu_src, reg_write, ADD.
//  - op 35 lw:   alu_src, mem_to_reg, reg_write, mem_read, ADD.
//  - op 43 sw:   alu_src, mem_write, ADD.
//  - op 4 beq:   branch, SUB.
//  - op 2 j:     jmp.
//  Handshake:
//  - in_ready = (!out_valid | out_ready) & !hazard.
//  - Accept when in_valid & in_ready: output register loads the decode, out_valid=1.
//  - On out_ready without accept: out_valid -> 0.
//  - Output bundle holds stable while out_valid & !out_ready.
//  Load-use interlock:
//  - hazard = in_valid & out_valid & out_mem_read & out_wr_reg!=0 & src match.
//  - src match: rs==out_wr_reg, or rt==out_wr_reg for op 0/43/4.
//  - On hazard with out_ready: the load leaves, out_valid -> 0 (one bubble cycle),
//    stall_cnt +1 (saturates at all-ones).
//  - Next cycle the hazard is clear and the instruction is accepted.
//  Flush (highest priority):
//  - out_valid -> 0 next edge; in_ready forced 1.
//  - Any presented instruction is consumed and discarded.
//  - No bubble is counted.
//  Reset (async, any time, incl. mid-stall):
//  - out_valid=0, all out_* fields and controls 0, stall_cnt=0.
//  - in_ready reflects the combinational rule (1 after reset).
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN:
//  - Defined: adds out_illegal (out, 1).
//  - An unlisted op, or op 0 with unlisted funct, is accepted with all controls 0
//    and out_illegal=1 for that bundle; out_illegal is 0 for legal bundles.
//  - Not defined: no port; such instructions decode silently as NOP.
// TESTING
//  1. Reset low mid-stream -> out_valid=0, stall_cnt=0, all controls 0 asynchronously.
//  2. Legal stream, out_ready=1: addi,lw,sw,add,beq,j -> one bundle per cycle, 1-cycle latency.
//     lw gives mem_read=1, mem_to_reg=1, alu_src=1; add gives wr_reg=rd.
//  3. lw $5 then add $6,$5,$7 back-to-back -> one out_valid=0 cycle between them,
//     in_ready=0 for 1 cycle, stall_cnt=1.
//  4. lw $0 then add using $0 -> no bubble, stall_cnt unchanged.
//  5. out_ready=0 for 3 cycles with a valid bundle -> outputs stable, in_ready=0;
//     releasing out_ready accepts the next instruction the same cycle.
//  6. flush with in_valid=1 during hazard -> both dropped, out_valid=0 next cycle, stall_cnt unchanged.
//     With DECODE_ILLEGAL_TRAP_EN, op 63 -> out_illegal=1 and all controls 0.

Source files
------------

// File: rtl/decode_stage.sv
// Registered MIPS-style decode stage: control decode, valid/ready on both sides,
// load-use interlock, flush. Optional DECODE_ILLEGAL_TRAP_EN adds out_illegal.
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 1
`define ALU_OP_SUB 2
`define ALU_OP_AND 3
`define ALU_OP_OR  4
`define ALU_OP_SLT 5
`endif

module decode_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 3,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_ins,
  input  logic [DATA_W-1:0]   in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_pc,
  output logic [REG_AW-1:0]   out_rs,
  output logic [REG_AW-1:0]   out_rt,
  output logic [REG_AW-1:0]   out_wr_reg,
  output logic [DATA_W-1:0]   out_imm,
  output logic [25:0]         out_jtarget,
  output logic                out_reg_dst,
  output logic                out_alu_src,
  output logic                out_mem_to_reg,
  output logic                out_reg_write,
  output logic                out_mem_read,
  output logic                out_mem_write,
  output logic                out_branch,
  output logic                out_jmp,
  output logic [ALU_OP_W-1:0] out_alu_op,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic                out_illegal,
`endif
  output logic [STALL_CW-1:0] stall_cnt
);

  // Handshake: a transfer happens on a side when its valid and ready are both
  // high at the rising edge; the output bundle is held while out_valid & !out_ready.
  logic [5:0]          w_op, w_funct;
  logic [REG_AW-1:0]   w_rs, w_rt, w_rd, w_wr_reg;
  logic                w_reg_dst, w_alu_src, w_mem_to_reg, w_reg_write;
  logic                w_mem_read, w_mem_write, w_branch, w_jmp;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_hazard, w_accept, w_src_match, w_unused_bits;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                w_illegal, r_illegal;
`endif

  logic                r_valid;
  logic [DATA_W-1:0]   r_pc, r_imm;
  logic [REG_AW-1:0]   r_rs, r_rt, r_wr_reg;
  logic [25:0]         r_jtarget;
  logic [7:0]          r_ctrl;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [STALL_CW-1:0] r_stall_cnt;

  assign w_op          = in_ins[31:26];
  assign w_funct       = in_ins[5:0];
  assign w_rs          = REG_AW'(in_ins[25:21]);
  assign w_rt          = REG_AW'(in_ins[20:16]);
  assign w_rd          = REG_AW'(in_ins[15:11]);
  assign w_unused_bits = ^in_ins;

  always_comb begin
    w_reg_dst = 1'b0; w_alu_src = 1'b0; w_mem_to_reg = 1'b0; w_reg_write = 1'b0;
    w_mem_read = 1'b0; w_mem_write = 1'b0; w_branch = 1'b0; w_jmp = 1'b0;
    w_alu_op = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    w_illegal = 1'b0;
`endif
    case (w_op)
      6'd0: begin
        case (w_funct)
          6'd32: w_alu_op = ALU_OP_W'(`ALU_OP_ADD);
          6'd34: w_alu_op = ALU_OP_W'(`ALU_OP_SUB);
          6'd36: w_alu_op = ALU_OP_W'(`ALU_OP_AND);
          6'd37: w_alu_op = ALU_OP_W'(`ALU_OP_OR);
          6'd42: w_alu_op = ALU_OP_W'(`ALU_OP_SLT);
          default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            w_illegal = 1'b1;
`endif
          end
        endcase
        if (w_funct == 6'd32 || w_funct == 6'd34 || w_funct == 6'd36 ||
            w_funct == 6'd37 || w_funct == 6'd42) begin
          w_reg_dst   = 1'b1;
          w_reg_write = 1'b1;
        end
      end
      6'd8: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = ALU_OP_W'(`ALU_OP_ADD);
      end
      6'd35: begin
        w_alu_src = 1'b1; w_mem_to_reg = 1'b1; w_reg_write = 1'b1; w_mem_read = 1'b1;
        w_alu_op = ALU_OP_W'(`ALU_OP_ADD);
      end
      6'd43: begin
        w_alu_src = 1'b1; w_mem_write = 1'b1; w_alu_op = ALU_OP_W'(`ALU_OP_ADD);
      end
      6'd4: begin
        w_branch = 1'b1; w_alu_op = ALU_OP_W'(`ALU_OP_SUB);
      end
      6'd2: w_jmp = 1'b1;
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        w_illegal = 1'b1;
`endif
      end
    endcase
  end

  assign w_wr_reg = w_reg_dst ? w_rd : w_rt;

  // rt is only a true source for R-type, sw and beq; for addi/lw it is the destination.
  assign w_src_match = (w_rs == r_wr_reg) ||
                       ((w_rt == r_wr_reg) && (w_op == 6'd0 || w_op == 6'd43 || w_op == 6'd4));
  assign w_hazard = in_valid && r_valid && r_ctrl[3] && (r_wr_reg != '0) && w_src_match;
  assign in_ready = flush || ((!r_valid || out_ready) && !w_hazard);
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0; r_pc <= '0; r_imm <= '0; r_rs <= '0; r_rt <= '0;
      r_wr_reg <= '0; r_jtarget <= '0; r_ctrl <= '0; r_alu_op <= '0;
      r_stall_cnt <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid   <= 1'b1;
        r_pc      <= in_pc;
        r_imm     <= {{(DATA_W-16){in_ins[15]}}, in_ins[15:0]};
        r_rs      <= w_rs;
        r_rt      <= w_rt;
        r_wr_reg  <= w_wr_reg;
        r_jtarget <= in_ins[25:0];
        r_ctrl    <= {w_reg_dst, w_alu_src, w_mem_to_reg, w_reg_write,
                      w_mem_read, w_mem_write, w_branch, w_jmp};
        r_alu_op  <= w_alu_op;
`ifdef DECODE_ILLEGAL_TRAP_EN
        r_illegal <= w_illegal;
`endif
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (!flush && w_hazard && out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid      = r_valid;
  assign out_pc         = r_pc;
  assign out_rs         = r_rs;
  assign out_rt         = r_rt;
  assign out_wr_reg     = r_wr_reg;
  assign out_imm        = r_imm;
  assign out_jtarget    = r_jtarget;
  assign out_reg_dst    = r_ctrl[7];
  assign out_alu_src    = r_ctrl[6];
  assign out_mem_to_reg = r_ctrl[5];
  assign out_reg_write  = r_ctrl[4];
  assign out_mem_read   = r_ctrl[3];
  assign out_mem_write  = r_ctrl[2];
  assign out_branch     = r_ctrl[1];
  assign out_jmp        = r_ctrl[0];
  assign out_alu_op     = r_alu_op;
  assign stall_cnt      = r_stall_cnt;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign out_illegal    = r_illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table vectors plus interlock,
// backpressure, flush and asynchronous reset sequences.
module tb_decode_stage;
  localparam logic [2:0] A_NONE = 3'd0, A_ADD = 3'd1, A_SUB = 3'd2,
                         A_AND = 3'd3, A_OR = 3'd4, A_SLT = 3'd5;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [31:0] in_ins = '0, in_pc = '0, out_pc, out_imm;
  logic [4:0]  out_rs, out_rt, out_wr_reg;
  logic [25:0] out_jtarget;
  logic out_reg_dst, out_alu_src, out_mem_to_reg, out_reg_write;
  logic out_mem_read, out_mem_write, out_branch, out_jmp;
  logic [2:0]  out_alu_op;
  logic [15:0] stall_cnt;
  logic [7:0]  ctrl;
  logic        illegal;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic out_illegal;
  assign illegal = out_illegal;
`else
  assign illegal = 1'b0;
`endif

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt), .out_wr_reg(out_wr_reg),
    .out_imm(out_imm), .out_jtarget(out_jtarget), .out_reg_dst(out_reg_dst),
    .out_alu_src(out_alu_src), .out_mem_to_reg(out_mem_to_reg),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jmp(out_jmp),
    .out_alu_op(out_alu_op),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .out_illegal(out_illegal),
`endif
    .stall_cnt(stall_cnt)
  );

  assign ctrl = {out_reg_dst, out_alu_src, out_mem_to_reg, out_reg_write,
                 out_mem_read, out_mem_write, out_branch, out_jmp};

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input int rs, rt, rd, funct);
    r_type = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction

  function automatic logic [31:0] i_type(input int op, rs, rt, input logic [15:0] imm);
    i_type = {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_ins   = ins;
    in_pc    = pc;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  wr;
    logic [7:0]  ctrl;   // reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jmp
    logic [2:0]  alu;
    logic        ill;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] exp_imm;
    vecs[0]  = '{i_type(8, 2, 1, 16'd5),      5'd1,  8'b0101_0000, A_ADD,  1'b0}; // addi
    vecs[1]  = '{i_type(35, 4, 3, 16'd8),     5'd3,  8'b0111_1000, A_ADD,  1'b0}; // lw
    vecs[2]  = '{i_type(43, 6, 5, 16'hFFFC),  5'd5,  8'b0100_0100, A_ADD,  1'b0}; // sw
    vecs[3]  = '{r_type(8, 9, 7, 32),         5'd7,  8'b1001_0000, A_ADD,  1'b0}; // add
    vecs[4]  = '{i_type(4, 1, 2, 16'd16),     5'd2,  8'b0000_0010, A_SUB,  1'b0}; // beq
    vecs[5]  = '{{6'd2, 26'h123456},          5'd18, 8'b0000_0001, A_NONE, 1'b0}; // j
    vecs[6]  = '{r_type(11, 12, 10, 34),      5'd10, 8'b1001_0000, A_SUB,  1'b0}; // sub
    vecs[7]  = '{r_type(14, 15, 13, 36),      5'd13, 8'b1001_0000, A_AND,  1'b0}; // and
    vecs[8]  = '{r_type(17, 18, 16, 37),      5'd16, 8'b1001_0000, A_OR,   1'b0}; // or
    vecs[9]  = '{r_type(20, 21, 19, 42),      5'd19, 8'b1001_0000, A_SLT,  1'b0}; // slt
    vecs[10] = '{r_type(0, 1, 2, 0),          5'd1,  8'b0000_0000, A_NONE, 1'b1}; // funct 0
    vecs[11] = '{i_type(63, 1, 2, 16'd3),     5'd2,  8'b0000_0000, A_NONE, 1'b1}; // op 63

    // reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_ctrl", 32'(ctrl), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    #9 rst_n = 1'b1;
    tick();

    // decode table, back-to-back with out_ready=1
    for (int i = 0; i < 12; i++) begin
      present(vecs[i].ins, 32'h1000 + 32'(4 * i));
      #1 check($sformatf("v%0d_in_ready", i), 32'(in_ready), 1);
      tick();
      exp_imm = {{16{vecs[i].ins[15]}}, vecs[i].ins[15:0]};
      check($sformatf("v%0d_valid", i), 32'(out_valid), 1);
      check($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(4 * i));
      check($sformatf("v%0d_rs", i), 32'(out_rs), 32'(vecs[i].ins[25:21]));
      check($sformatf("v%0d_rt", i), 32'(out_rt), 32'(vecs[i].ins[20:16]));
      check($sformatf("v%0d_wr_reg", i), 32'(out_wr_reg), 32'(vecs[i].wr));
      check($sformatf("v%0d_imm", i), out_imm, exp_imm);
      check($sformatf("v%0d_jtarget", i), 32'(out_jtarget), 32'(vecs[i].ins[25:0]));
      check($sformatf("v%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
      check($sformatf("v%0d_alu_op", i), 32'(out_alu_op), 32'(vecs[i].alu));
`ifdef DECODE_ILLEGAL_TRAP_EN
      check($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
`endif
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 0);
    check("no_stall_yet", 32'(stall_cnt), 0);

    // load-use: lw $5 then add $6,$5,$7
    present(i_type(35, 1, 5, 16'd0), 32'h2000);
    tick();
    present(r_type(5, 7, 6, 32), 32'h2004);
    #1 check("lu_in_ready_low", 32'(in_ready), 0);
    tick();
    check("lu_bubble", 32'(out_valid), 0);
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    check("lu_in_ready_back", 32'(in_ready), 1);
    tick();
    check("lu_add_valid", 32'(out_valid), 1);
    check("lu_add_pc", out_pc, 32'h2004);
    check("lu_add_wr", 32'(out_wr_reg), 6);
    check("lu_stall_hold", 32'(stall_cnt), 1);

    // lw $0 then add using $0: no interlock
    present(i_type(35, 1, 0, 16'd0), 32'h3000);
    tick();
    present(r_type(0, 7, 6, 32), 32'h3004);
    #1 check("z_in_ready", 32'(in_ready), 1);
    tick();
    check("z_valid", 32'(out_valid), 1);
    check("z_pc", out_pc, 32'h3004);
    check("z_stall", 32'(stall_cnt), 1);
    in_valid = 1'b0;
    tick();

    // backpressure: hold 3 cycles, release accepts next instruction same cycle
    present(i_type(8, 1, 2, 16'd7), 32'h4000);
    tick();
    out_ready = 1'b0;
    present(i_type(8, 1, 3, 16'd9), 32'h4004);
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 0);
      tick();
      check($sformatf("bp%0d_valid", c), 32'(out_valid), 1);
      check($sformatf("bp%0d_imm", c), out_imm, 7);
      check($sformatf("bp%0d_pc", c), out_pc, 32'h4000);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready), 1);
    tick();
    check("bp_next_imm", out_imm, 9);
    check("bp_next_pc", out_pc, 32'h4004);
    in_valid = 1'b0;
    tick();

    // flush during hazard: both dropped, no bubble counted
    present(i_type(35, 1, 5, 16'd0), 32'h5000);
    tick();
    present(r_type(5, 7, 6, 32), 32'h5004);
    flush = 1'b1;
    #1 check("fl_in_ready", 32'(in_ready), 1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 32'(out_valid), 0);
    check("fl_stall", 32'(stall_cnt), 1);
    tick();
    check("fl_dropped", 32'(out_valid), 0);

    // async reset mid-stall
    present(i_type(35, 1, 5, 16'd0), 32'h6000);
    tick();
    out_ready = 1'b0;
    present(r_type(5, 7, 6, 32), 32'h6004);
    tick();
    check("ar_stalled_ready", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 0);
    check("ar_stall", 32'(stall_cnt), 0);
    check("ar_ctrl", 32'(ctrl), 0);
    check("ar_pc", out_pc, 0);
    check("ar_in_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    check("ar_after_valid", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
